fetch_decode_reg: RTL and testbench
===================================

# fetch_decode_reg

IF/ID pipeline register placed directly after the Fetch stage. Each cycle it consumes the 16-bit instruction word and PC values from Fetch and presents one complete instruction (opcode word, plus its 16-bit immediate when the opcode needs one) to Decode. Immediate-carrying instructions occupy two consecutive fetched words, so a small FSM assembles them. The block also applies pipeline stall and flush.

## Interface
Parameters:
- `NOP_WORD`, default 16'h0000: instruction driven during bubbles and after reset or flush.
- `IMM_CLASS`, default 2'b11: value of `instruction[15:14]` that marks an opcode followed by an immediate word.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard stall; holds all state and outputs.
- `flush`  in  1  branch, jump or interrupt redirect; discards in-flight contents.
- `instruction`  in  16  word fetched this cycle.
- `samePc`  in  32  address of `instruction`.
- `nextPc`  in  32  `samePc + 1`.
- `instrOut`  out  16  opcode word to Decode.
- `immOut`  out  16  immediate; 0 when the opcode has none.
- `pcOut`  out  32  address of the opcode word.
- `nextPcOut`  out  32  address after the last word the instruction consumed.
- `hasImm`  out  1  `immOut` is meaningful.
- `validOut`  out  1  the output bundle is a real instruction, not a bubble.

## Operation
- FSM states: `S_OP` (expecting an opcode word) and `S_IMM` (expecting the immediate word).
- Priority, highest first: `rst` > `flush` > `stall` > normal operation.
- Reset values: state `S_OP`; `instrOut = NOP_WORD`; `immOut`, `pcOut` and `nextPcOut` all 0; `hasImm` and `validOut` both 0; holding registers cleared.
- `S_OP`, word without an immediate (`instruction[15:14] != IMM_CLASS`):
  - Register `instrOut = instruction`, `immOut = 0`, `pcOut = samePc`, `nextPcOut = nextPc`.
  - Set `hasImm = 0` and `validOut = 1`. Stay in `S_OP`.
- `S_OP`, immediate opcode:
  - Capture `instruction` and `samePc` into holding registers.
  - Outputs become a bubble: `validOut = 0`, `instrOut = NOP_WORD`, `hasImm = 0`. Go to `S_IMM`.
- `S_IMM`, any word:
  - The word is taken as data and is never decoded.
  - Register `instrOut` = held opcode, `immOut = instruction`, `pcOut` = held PC, `nextPcOut = nextPc`.
  - Set `hasImm = 1` and `validOut = 1`. Go to `S_OP`.
- `stall = 1`: state, holding registers and all outputs keep their values. The input word is ignored; Fetch re-presents it while stalled.
- `flush = 1`, including when `stall = 1` in the same cycle:
  - Outputs return to reset values and state to `S_OP`.
  - A half-assembled instruction in `S_IMM` is dropped.
- `rst` in the middle of assembly: same result as flush, plus all registers cleared.

## Timing
- Every output is registered. There is no combinational path from any input to any output.
- Opcode without immediate: appears on the outputs 1 cycle after it is presented.
- Opcode with immediate:
  - One bubble cycle follows the opcode word.
  - The full instruction appears 1 cycle after the immediate word, i.e. 2 cycles after the opcode word when no stall occurs.
- A stall during `S_IMM` extends the wait. The bubble stays on the outputs for the whole stall.
- Back-to-back immediate instructions give the pattern bubble, valid, bubble, valid.
- A flush with `rst = 0` takes effect on the next edge. The word presented with it is discarded, not captured.

## Structure
- Package `pipe_pkg` holds:
  - the FSM state enum (`S_OP`, `S_IMM`);
  - `NOP_WORD`;
  - opcode-class field positions ([15:14]) and `IMM_CLASS`;
  - an `ifid_bundle_t` struct grouping `instrOut`, `immOut`, `pcOut`, `nextPcOut`, `hasImm` and `validOut`, for reuse by the ID/EX register.
- One sub-module, `imm_detect`: combinational; input `instruction[15:0]`, output `needsImm`. Decode reuses it for hazard counting.
- Everything else stays inline: FSM, holding registers, output register.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with arbitrary inputs. Required: `validOut = 0`, `instrOut = 16'h0000`, `pcOut = 0`, state `S_OP`.
- **Plain sequence.** Present `16'h1234` @ PC 5 then `16'h2001` @ PC 6. Required:
  - next cycle: `validOut = 1`, `instrOut = 16'h1234`, `pcOut = 5`, `nextPcOut = 6`, `hasImm = 0`;
  - following cycle: `16'h2001` with `pcOut = 6`.
- **Immediate assembly.** Present `16'hC010` @ PC 8, then `16'hBEEF` @ PC 9. Required:
  - cycle +1: bubble;
  - cycle +2: `instrOut = 16'hC010`, `immOut = 16'hBEEF`, `pcOut = 8`, `nextPcOut = 10`, `hasImm = 1`, `validOut = 1`.
- **Stall inside assembly.** Present `16'hC010`, then hold `stall` for 3 cycles, then present `16'h0042`. Required: bubble on the outputs for all 3 stall cycles, then `immOut = 16'h0042`.
- **Flush beats stall.** In `S_IMM`, assert `flush` and `stall` together, then present `16'h1111` @ PC 32. Required:
  - after the flush edge: bubble, state `S_OP`, held opcode discarded;
  - next: `instrOut = 16'h1111`, `pcOut = 32`, `hasImm = 0`.
- **Reset during assembly.** Assert `rst` in `S_IMM`. Required: all outputs at reset values, and the next word is decoded as an opcode.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared IF/ID definitions: FSM states, opcode-class field layout and the
// registered bundle handed from the IF/ID register to Decode and ID/EX.
package pipe_pkg;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

  localparam logic [15:0] NOP_WORD    = 16'h0000;
  localparam int          OPCLASS_MSB = 15;
  localparam int          OPCLASS_LSB = 14;
  localparam logic [1:0]  IMM_CLASS   = 2'b11;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        has_imm;
    logic        valid;
  } ifid_bundle_t;

  function automatic logic [1:0] opclass(input logic [15:0] word);
    return word[OPCLASS_MSB:OPCLASS_LSB];
  endfunction

endpackage

// File: rtl/imm_detect.sv
// Flags opcode words that are followed by a 16-bit immediate word.
// Purely combinational so Decode can reuse it for hazard counting.
module imm_detect
  import pipe_pkg::opclass;
#(
  parameter logic [1:0] IMM_CLASS = pipe_pkg::IMM_CLASS
) (
  input  logic [15:0] instruction,
  output logic        needsImm
);

  assign needsImm = (opclass(instruction) == IMM_CLASS);

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register: assembles opcode+immediate pairs from consecutive
// fetched words and applies stall and flush. All outputs are registered.
module fetch_decode_reg
  import pipe_pkg::state_e;
  import pipe_pkg::S_OP;
  import pipe_pkg::S_IMM;
  import pipe_pkg::ifid_bundle_t;
#(
  parameter logic [15:0] NOP_WORD  = pipe_pkg::NOP_WORD,
  parameter logic [1:0]  IMM_CLASS = pipe_pkg::IMM_CLASS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] instruction,
  input  logic [31:0] samePc,
  input  logic [31:0] nextPc,
  output logic [15:0] instrOut,
  output logic [15:0] immOut,
  output logic [31:0] pcOut,
  output logic [31:0] nextPcOut,
  output logic        hasImm,
  output logic        validOut
);

  localparam ifid_bundle_t BUBBLE = '{
    instr:   NOP_WORD,
    imm:     16'h0000,
    pc:      32'h0,
    next_pc: 32'h0,
    has_imm: 1'b0,
    valid:   1'b0
  };

  state_e       r_state;
  logic [15:0]  r_held_instr;
  logic [31:0]  r_held_pc;
  ifid_bundle_t r_out;
  logic         w_needs_imm;

  imm_detect #(
    .IMM_CLASS(IMM_CLASS)
  ) u_imm_detect (
    .instruction(instruction),
    .needsImm   (w_needs_imm)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // Flush behaves like reset so a half-assembled instruction is dropped.
      r_state      <= S_OP;
      r_held_instr <= '0;
      r_held_pc    <= '0;
      r_out        <= BUBBLE;
    end else if (!stall) begin
      case (r_state)
        S_OP: begin
          if (w_needs_imm) begin
            r_held_instr <= instruction;
            r_held_pc    <= samePc;
            r_out        <= BUBBLE;
            r_state      <= S_IMM;
          end else begin
            r_out <= '{
              instr:   instruction,
              imm:     16'h0000,
              pc:      samePc,
              next_pc: nextPc,
              has_imm: 1'b0,
              valid:   1'b1
            };
          end
        end
        S_IMM: begin
          // This word is immediate data and is never looked at as an opcode.
          r_out <= '{
            instr:   r_held_instr,
            imm:     instruction,
            pc:      r_held_pc,
            next_pc: nextPc,
            has_imm: 1'b1,
            valid:   1'b1
          };
          r_state <= S_OP;
        end
        default: r_state <= S_OP;
      endcase
    end
  end

  assign instrOut  = r_out.instr;
  assign immOut    = r_out.imm;
  assign pcOut     = r_out.pc;
  assign nextPcOut = r_out.next_pc;
  assign hasImm    = r_out.has_imm;
  assign validOut  = r_out.valid;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed bench for fetch_decode_reg: literal expectations per transaction
// plus a pending-opcode reference model compared on every cycle.
module tb_fetch_decode_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [31:0] samePc = 32'h0;
  logic [31:0] nextPc = 32'h1;
  logic [15:0] instrOut;
  logic [15:0] immOut;
  logic [31:0] pcOut;
  logic [31:0] nextPcOut;
  logic        hasImm;
  logic        validOut;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_decode_reg dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .instruction(instruction),
    .samePc     (samePc),
    .nextPc     (nextPc),
    .instrOut   (instrOut),
    .immOut     (immOut),
    .pcOut      (pcOut),
    .nextPcOut  (nextPcOut),
    .hasImm     (hasImm),
    .validOut   (validOut)
  );

  // Reference model: an instruction is "pending" while its opcode waits for the immediate.
  logic        m_ready = 1'b0;
  logic        m_pend = 1'b0;
  logic [15:0] m_word = 16'h0;
  logic [31:0] m_pc = 32'h0;
  logic [15:0] e_instr = 16'h0;
  logic [15:0] e_imm = 16'h0;
  logic [31:0] e_pc = 32'h0;
  logic [31:0] e_npc = 32'h0;
  logic        e_has = 1'b0;
  logic        e_valid = 1'b0;
  logic        e_full = 1'b1;

  always @(posedge clk) begin
    if (rst || flush) begin
      m_ready <= m_ready | rst;
      m_pend  <= 1'b0;
      e_instr <= 16'h0000;
      e_imm   <= 16'h0;
      e_pc    <= 32'h0;
      e_npc   <= 32'h0;
      e_has   <= 1'b0;
      e_valid <= 1'b0;
      e_full  <= 1'b1;
    end else if (!stall) begin
      if (m_pend) begin
        e_instr <= m_word;
        e_imm   <= instruction;
        e_pc    <= m_pc;
        e_npc   <= samePc + 32'd1;
        e_has   <= 1'b1;
        e_valid <= 1'b1;
        e_full  <= 1'b1;
        m_pend  <= 1'b0;
      end else if (instruction[15:14] == 2'b11) begin
        m_pend  <= 1'b1;
        m_word  <= instruction;
        m_pc    <= samePc;
        e_instr <= 16'h0000;
        e_has   <= 1'b0;
        e_valid <= 1'b0;
        e_full  <= 1'b0;
      end else begin
        e_instr <= instruction;
        e_imm   <= 16'h0;
        e_pc    <= samePc;
        e_npc   <= samePc + 32'd1;
        e_has   <= 1'b0;
        e_valid <= 1'b1;
        e_full  <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      chk("model validOut", {31'b0, validOut}, {31'b0, e_valid});
      chk("model instrOut", {16'b0, instrOut}, {16'b0, e_instr});
      chk("model hasImm", {31'b0, hasImm}, {31'b0, e_has});
      if (e_full) begin
        chk("model immOut", {16'b0, immOut}, {16'b0, e_imm});
        chk("model pcOut", pcOut, e_pc);
        chk("model nextPcOut", nextPcOut, e_npc);
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic s,
                     input logic [15:0] w, input logic [31:0] pc);
    rst = r;
    flush = f;
    stall = s;
    instruction = w;
    samePc = pc;
    nextPc = pc + 32'd1;
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b flush=%b stall=%b in=%h@%0d -> valid=%b instr=%h imm=%h pc=%0d npc=%0d has=%b",
             $time, r, f, s, w, pc, validOut, instrOut, immOut, pcOut, nextPcOut, hasImm);
  endtask

  task automatic exp_valid(input string name, input logic [15:0] ins, input logic [15:0] imm,
                           input logic [31:0] pc, input logic [31:0] npc, input logic has);
    chk({name, " validOut"}, {31'b0, validOut}, 32'd1);
    chk({name, " instrOut"}, {16'b0, instrOut}, {16'b0, ins});
    chk({name, " immOut"}, {16'b0, immOut}, {16'b0, imm});
    chk({name, " pcOut"}, pcOut, pc);
    chk({name, " nextPcOut"}, nextPcOut, npc);
    chk({name, " hasImm"}, {31'b0, hasImm}, {31'b0, has});
  endtask

  task automatic exp_bubble(input string name);
    chk({name, " validOut"}, {31'b0, validOut}, 32'd0);
    chk({name, " instrOut"}, {16'b0, instrOut}, 32'h0000);
    chk({name, " hasImm"}, {31'b0, hasImm}, 32'd0);
  endtask

  task automatic exp_reset(input string name);
    exp_bubble(name);
    chk({name, " immOut"}, {16'b0, immOut}, 32'd0);
    chk({name, " pcOut"}, pcOut, 32'd0);
    chk({name, " nextPcOut"}, nextPcOut, 32'd0);
  endtask

  initial begin
    // Reset for two cycles with arbitrary inputs
    cyc(1'b1, 1'b0, 1'b0, 16'hC010, 32'd77);
    cyc(1'b1, 1'b0, 1'b1, 16'h1234, 32'd99);
    exp_reset("reset");

    // Plain sequence
    cyc(1'b0, 1'b0, 1'b0, 16'h1234, 32'd5);
    exp_valid("plain0", 16'h1234, 16'h0, 32'd5, 32'd6, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h2001, 32'd6);
    exp_valid("plain1", 16'h2001, 16'h0, 32'd6, 32'd7, 1'b0);

    // Immediate assembly
    cyc(1'b0, 1'b0, 1'b0, 16'hC010, 32'd8);
    exp_bubble("imm bubble");
    cyc(1'b0, 1'b0, 1'b0, 16'hBEEF, 32'd9);
    exp_valid("imm full", 16'hC010, 16'hBEEF, 32'd8, 32'd10, 1'b1);

    // Stall inside assembly
    cyc(1'b0, 1'b0, 1'b0, 16'hC010, 32'd10);
    exp_bubble("stall bubble");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'h0042, 32'd11);
      exp_bubble("stall hold");
    end
    cyc(1'b0, 1'b0, 1'b0, 16'h0042, 32'd11);
    exp_valid("stall release", 16'hC010, 16'h0042, 32'd10, 32'd12, 1'b1);

    // Stall on a valid instruction holds it
    cyc(1'b0, 1'b0, 1'b1, 16'h0777, 32'd13);
    exp_valid("stall valid hold", 16'hC010, 16'h0042, 32'd10, 32'd12, 1'b1);

    // Flush beats stall in S_IMM
    cyc(1'b0, 1'b0, 1'b0, 16'hC020, 32'd20);
    exp_bubble("flush pre");
    cyc(1'b0, 1'b1, 1'b1, 16'h5555, 32'd21);
    exp_reset("flush");
    cyc(1'b0, 1'b0, 1'b0, 16'h1111, 32'd32);
    exp_valid("after flush", 16'h1111, 16'h0, 32'd32, 32'd33, 1'b0);

    // Reset during assembly
    cyc(1'b0, 1'b0, 1'b0, 16'hC030, 32'd40);
    exp_bubble("rst pre");
    cyc(1'b1, 1'b0, 1'b0, 16'h7777, 32'd41);
    exp_reset("rst mid");
    cyc(1'b0, 1'b0, 1'b0, 16'h3456, 32'd50);
    exp_valid("after rst", 16'h3456, 16'h0, 32'd50, 32'd51, 1'b0);

    // Back-to-back immediates; second data word itself looks like an imm opcode
    cyc(1'b0, 1'b0, 1'b0, 16'hC001, 32'd60);
    exp_bubble("b2b bubble0");
    cyc(1'b0, 1'b0, 1'b0, 16'h0101, 32'd61);
    exp_valid("b2b valid0", 16'hC001, 16'h0101, 32'd60, 32'd62, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 16'hC002, 32'd62);
    exp_bubble("b2b bubble1");
    cyc(1'b0, 1'b0, 1'b0, 16'hFFFF, 32'd63);
    exp_valid("b2b valid1", 16'hC002, 16'hFFFF, 32'd62, 32'd64, 1'b1);

    // Class 2'b10 and 2'b01 are not immediate-carrying
    cyc(1'b0, 1'b0, 1'b0, 16'h8000, 32'd70);
    exp_valid("class10", 16'h8000, 16'h0, 32'd70, 32'd71, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h7FFF, 32'd71);
    exp_valid("class01", 16'h7FFF, 16'h0, 32'd71, 32'd72, 1'b0);

    // Flush without stall on a valid output
    cyc(1'b0, 1'b1, 1'b0, 16'h2222, 32'd80);
    exp_reset("flush plain");
    cyc(1'b0, 1'b0, 1'b0, 16'h2223, 32'd81);
    exp_valid("after flush2", 16'h2223, 16'h0, 32'd81, 32'd82, 1'b0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
